// File: rtl/verificador_vitoria_if.sv
// Board-reader handshake between the game-control FSM and the win checker.
//   iniciar          : start request from the controller
//   board_x, board_o : 9-bit occupancy maps (bit i = row i/3, column i%3)
//   ocupado, pronto  : busy level and one-cycle done pulse
//   vencedor, linha, empate, fim_jogo, erro : registered scan results
// master = controller side, slave = checker side.
interface verificador_vitoria_if;
  logic       iniciar;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic       ocupado;
  logic       pronto;
  logic [1:0] vencedor;
  logic [2:0] linha;
  logic       empate;
  logic       fim_jogo;
  logic       erro;

  modport master (
    output iniciar, board_x, board_o,
    input  ocupado, pronto, vencedor, linha, empate, fim_jogo, erro
  );

  modport slave (
    input  iniciar, board_x, board_o,
    output ocupado, pronto, vencedor, linha, empate, fim_jogo, erro
  );
endinterface

// File: rtl/verificador_vitoria.sv
// Tic-tac-toe win checker. On an accepted iniciar it snapshots both boards,
// then evaluates the 8 winning lines one per cycle and reports winner,
// winning line, draw and overlap error, finishing with a pronto pulse.
// Ports:
//   clock   : rising-edge clock
//   clear_n : synchronous active-low reset
//   vi      : slave side of verificador_vitoria_if (start, boards, results)
// VARREDURA_COMPLETA = 1 always walks all 8 lines for constant latency; the
// reported line is still the first hit in scan order.
module verificador_vitoria #(
  parameter bit VARREDURA_COMPLETA = 1'b0
) (
  input logic                   clock,
  input logic                   clear_n,
  verificador_vitoria_if.slave  vi
);

  typedef enum logic [1:0] {OCIOSO, CAPTURA, VERIFICA, FIM} estado_t;

  estado_t    estado, estado_prox;
  logic [8:0] snap_x, snap_o;
  logic [2:0] indice;
  logic       achou;
  logic [1:0] vencedor_r;
  logic [2:0] linha_r;
  logic       empate_r, fim_jogo_r, erro_r;

  // Cell mask for each winning line, in scan order.
  function automatic logic [8:0] mascara(input logic [2:0] i);
    case (i)
      3'd0:    mascara = 9'b000000111;
      3'd1:    mascara = 9'b000111000;
      3'd2:    mascara = 9'b111000000;
      3'd3:    mascara = 9'b001001001;
      3'd4:    mascara = 9'b010010010;
      3'd5:    mascara = 9'b100100100;
      3'd6:    mascara = 9'b100010001;
      default: mascara = 9'b001010100;
    endcase
  endfunction

  logic [8:0] m;
  logic       x_cheia, o_cheia, acerto_novo, cheio, ultimo, encerra;

  assign m           = mascara(indice);
  assign x_cheia     = (snap_x & m) == m;
  assign o_cheia     = (snap_o & m) == m;
  // Only the first hit in scan order is recorded; later ones are ignored.
  assign acerto_novo = !achou && (x_cheia || o_cheia);
  assign cheio       = &(snap_x | snap_o);
  assign ultimo      = (indice == 3'd7);
  assign encerra     = ultimo || (!VARREDURA_COMPLETA && acerto_novo);

  always_ff @(posedge clock) begin
    if (!clear_n) estado <= OCIOSO;
    else          estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (vi.iniciar) estado_prox = CAPTURA;
      CAPTURA:  estado_prox = (|(vi.board_x & vi.board_o)) ? FIM : VERIFICA;
      VERIFICA: if (encerra) estado_prox = FIM;
      default:  estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      snap_x     <= '0;
      snap_o     <= '0;
      indice     <= '0;
      achou      <= 1'b0;
      vencedor_r <= '0;
      linha_r    <= '0;
      empate_r   <= 1'b0;
      fim_jogo_r <= 1'b0;
      erro_r     <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: if (vi.iniciar) begin
          achou      <= 1'b0;
          vencedor_r <= '0;
          linha_r    <= '0;
          empate_r   <= 1'b0;
          fim_jogo_r <= 1'b0;
          erro_r     <= 1'b0;
        end
        CAPTURA: begin
          snap_x <= vi.board_x;
          snap_o <= vi.board_o;
          indice <= '0;
          if (|(vi.board_x & vi.board_o)) erro_r <= 1'b1;
        end
        VERIFICA: begin
          if (acerto_novo) begin
            achou      <= 1'b1;
            vencedor_r <= x_cheia ? 2'b01 : 2'b10;
            linha_r    <= indice;
          end
          if (encerra) begin
            // Draw only when the whole scan found no line at all.
            empate_r   <= !(achou || acerto_novo) && cheio;
            fim_jogo_r <= achou || acerto_novo || cheio;
          end else begin
            indice <= indice + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign vi.ocupado  = (estado == CAPTURA) || (estado == VERIFICA);
  assign vi.pronto   = (estado == FIM);
  assign vi.vencedor = vencedor_r;
  assign vi.linha    = linha_r;
  assign vi.empate   = empate_r;
  assign vi.fim_jogo = fim_jogo_r;
  assign vi.erro     = erro_r;

endmodule

// File: tb/tb_verificador_vitoria.sv
module tb_verificador_vitoria;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  verificador_vitoria_if if0();
  verificador_vitoria_if if1();

  verificador_vitoria #(.VARREDURA_COMPLETA(1'b0)) d0 (.clock(clock), .clear_n(clear_n), .vi(if0));
  verificador_vitoria #(.VARREDURA_COMPLETA(1'b1)) d1 (.clock(clock), .clear_n(clear_n), .vi(if1));

  typedef struct {
    int         ciclo;
    logic [1:0] v;
    logic [2:0] l;
    logic       e, f, er;
  } esperado_t;

  esperado_t q0[$];
  esperado_t q1[$];
  esperado_t e0, e1;

  int ciclo = 0;
  int n_ini = 0;
  int asserts = 0;
  int falhas = 0;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic check(input string nome, input int got, input int exp);
    asserts++;
    if (got != exp) begin
      falhas++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, got, exp, ciclo);
    end
  endtask

  // Scoreboard monitors: one per DUT, compare on every pronto.
  always @(negedge clock) begin
    if (if0.pronto === 1'b1) begin
      if (q0.size() == 0) check("d0 unexpected pronto", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("d0 pronto cycle", ciclo, e0.ciclo);
        check("d0 vencedor", int'(if0.vencedor), int'(e0.v));
        check("d0 linha", int'(if0.linha), int'(e0.l));
        check("d0 empate", int'(if0.empate), int'(e0.e));
        check("d0 fim_jogo", int'(if0.fim_jogo), int'(e0.f));
        check("d0 erro", int'(if0.erro), int'(e0.er));
      end
    end
  end

  always @(negedge clock) begin
    if (if1.pronto === 1'b1) begin
      if (q1.size() == 0) check("d1 unexpected pronto", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("d1 pronto cycle", ciclo, e1.ciclo);
        check("d1 vencedor", int'(if1.vencedor), int'(e1.v));
        check("d1 linha", int'(if1.linha), int'(e1.l));
        check("d1 empate", int'(if1.empate), int'(e1.e));
        check("d1 fim_jogo", int'(if1.fim_jogo), int'(e1.f));
        check("d1 erro", int'(if1.erro), int'(e1.er));
      end
    end
  end

  task automatic boards(input logic [8:0] bx, input logic [8:0] bo);
    if0.board_x = bx; if0.board_o = bo;
    if1.board_x = bx; if1.board_o = bo;
  endtask

  task automatic dispara(input logic [8:0] bx, input logic [8:0] bo);
    @(posedge clock); #1;
    boards(bx, bo);
    if0.iniciar = 1'b1; if1.iniciar = 1'b1;
    n_ini = ciclo;
  endtask

  task automatic segura(input int dur);
    repeat (dur) @(posedge clock);
    #1;
    if0.iniciar = 1'b0; if1.iniciar = 1'b0;
  endtask

  task automatic espera(input logic [1:0] v, input logic [2:0] l,
                        input logic e, input logic f, input logic er,
                        input int lat0, input int lat1);
    esperado_t x;
    x.v = v; x.l = l; x.e = e; x.f = f; x.er = er;
    x.ciclo = n_ini + lat0; q0.push_back(x);
    x.ciclo = n_ini + lat1; q1.push_back(x);
  endtask

  task automatic aguarda();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 40) begin
      @(posedge clock);
      k++;
    end
    check("scan completed within budget", int'(q0.size() + q1.size()), 0);
  endtask

  task automatic partida(input logic [8:0] bx, input logic [8:0] bo,
                         input logic [1:0] v, input logic [2:0] l,
                         input logic e, input logic f, input logic er,
                         input int lat0, input int lat1);
    dispara(bx, bo);
    espera(v, l, e, f, er, lat0, lat1);
    segura(1);
    aguarda();
  endtask

  task automatic zeros(input string nome);
    check({nome, " d0 outputs"}, int'({if0.ocupado, if0.pronto, if0.vencedor, if0.linha,
                                       if0.empate, if0.fim_jogo, if0.erro}), 0);
    check({nome, " d1 outputs"}, int'({if1.ocupado, if1.pronto, if1.vencedor, if1.linha,
                                       if1.empate, if1.fim_jogo, if1.erro}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with iniciar high: everything stays cleared.
    boards(9'b000000111, 9'b000011000);
    if0.iniciar = 1'b1; if1.iniciar = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    zeros("reset");
    #1;
    if0.iniciar = 1'b0; if1.iniciar = 1'b0;
    clear_n = 1'b1;
    repeat (12) @(posedge clock);
    @(negedge clock);
    zeros("idle after reset");

    // X row 0
    partida(9'b000000111, 9'b000011000, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 3, 10);
    // O anti-diagonal, line 7
    partida(9'b000001001, 9'b001010100, 2'b10, 3'd7, 1'b0, 1'b1, 1'b0, 10, 10);
    // Draw
    partida(9'b110001101, 9'b001110010, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0, 10, 10);
    // Overlap error
    partida(9'b000000001, 9'b000000001, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 2, 2);
    // Empty board
    partida(9'b000000000, 9'b000000000, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 10, 10);
    // X column 2 (line 5)
    partida(9'b100100100, 9'b000001011, 2'b01, 3'd5, 1'b0, 1'b1, 1'b0, 8, 10);
    // Both players have a line: O row 0 comes first in scan order
    partida(9'b111000000, 9'b000000111, 2'b10, 3'd0, 1'b0, 1'b1, 1'b0, 3, 10);

    // Mid-scan board change to an X win is ignored.
    dispara(9'b110001101, 9'b001110010);
    espera(2'b00, 3'd0, 1'b1, 1'b1, 1'b0, 10, 10);
    segura(1);
    repeat (2) @(posedge clock);
    #1 boards(9'b000000111, 9'b000000000);
    aguarda();

    // iniciar held 5 cycles: d0 re-triggers once after FIM, d1 ignores
    // the requests made while busy.
    dispara(9'b000000111, 9'b000011000);
    espera(2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 3, 10);
    q0.push_back('{ciclo: n_ini + 7, v: 2'b01, l: 3'd0, e: 1'b0, f: 1'b1, er: 1'b0});
    segura(5);
    aguarda();
    // Results hold after the pronto pulse.
    @(negedge clock);
    check("d0 vencedor held", int'(if0.vencedor), 1);
    check("d1 fim_jogo held", int'(if1.fim_jogo), 1);

    // Reset in cycle n+4 of a no-win scan: no pronto, outputs cleared.
    dispara(9'b110001101, 9'b001110010);
    segura(1);
    repeat (3) @(posedge clock);
    #1 clear_n = 1'b0;
    @(posedge clock);
    #1 clear_n = 1'b1;
    @(negedge clock);
    zeros("after mid-scan reset");
    repeat (14) @(posedge clock);
    @(negedge clock);
    zeros("no scan after reset");
    check("queues empty", int'(q0.size() + q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, falhas);
    $finish;
  end

endmodule
